// File: rtl/unsigned_div_reconstructor_pkg.sv
// Shared constants and state encoding for the divider round-trip reconstructor.
package unsigned_div_reconstructor_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int CNT_W     = $clog2(WIDTH_DEF);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter width for an arbitrary operand width, never narrower than one bit.
    function automatic int cntWidth(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/unsigned_div_reconstructor_shift_add_datapath.sv
// Shift-and-add multiplier core: acc accumulates mcand whenever the low multiplier bit is set.
module unsigned_div_reconstructor_shift_add_datapath
    import unsigned_div_reconstructor_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_load,
    input  logic                 i_step,
    input  logic [WIDTH-1:0]     i_quotient,
    input  logic [WIDTH-1:0]     i_divisor,
    input  logic [WIDTH-1:0]     i_remainder,
    output logic [2*WIDTH-1:0]   o_accNext
);

    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] w_accNext;

    // The value acc takes on this step; the top latches it as the result on the last step.
    always_comb begin
        w_accNext = r_acc;
        if (r_mplier[0]) begin
            w_accNext = r_acc + r_mcand;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
        end else if (i_load) begin
            r_acc    <= {{WIDTH{1'b0}}, i_remainder};
            r_mcand  <= {{WIDTH{1'b0}}, i_divisor};
            r_mplier <= i_quotient;
        end else if (i_step) begin
            r_acc    <= w_accNext;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
        end
    end

    assign o_accNext = w_accNext;

endmodule

// File: rtl/unsigned_div_reconstructor.sv
// Rebuilds dividend = quotient*divisor + remainder with fixed WIDTH-cycle latency and
// flags triples that the divider could not have produced.
module unsigned_div_reconstructor
    import unsigned_div_reconstructor_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     quotient,
    input  logic [WIDTH-1:0]     divisor,
    input  logic [WIDTH-1:0]     remainder,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   dividend,
    output logic                 div0,
    output logic                 rem_err
);

    localparam int CW = cntWidth(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    state_t             r_state;
    state_t             w_stateNext;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_dividend;
    logic               r_div0;
    logic               r_remErr;
    logic               w_load;
    logic               w_step;
    logic               w_lastStep;
    logic [2*WIDTH-1:0] w_accNext;

    unsigned_div_reconstructor_shift_add_datapath #(
        .WIDTH(WIDTH)
    ) u_datapath (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_load),
        .i_step      (w_step),
        .i_quotient  (quotient),
        .i_divisor   (divisor),
        .i_remainder (remainder),
        .o_accNext   (w_accNext)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    assign w_lastStep = (r_cnt == LAST_CNT);

    always_comb begin
        w_stateNext = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_load      = 1'b1;
                    w_stateNext = RUN;
                end
            end
            RUN: begin
                w_step = 1'b1;
                if (w_lastStep) begin
                    w_stateNext = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_stateNext = IDLE;
                end
            end
            default: w_stateNext = IDLE;
        endcase
    end

    // Result and flags change only on load or on the final step, so they hold through DONE and IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_dividend <= '0;
            r_div0     <= 1'b0;
            r_remErr   <= 1'b0;
        end else begin
            if (w_load) begin
                r_cnt    <= '0;
                r_div0   <= (divisor == '0);
                r_remErr <= (divisor != '0) && (remainder >= divisor);
            end
            if (w_step) begin
                r_cnt <= r_cnt + 1'b1;
                if (w_lastStep) begin
                    r_dividend <= w_accNext;
                end
            end
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign dividend  = r_dividend;
    assign div0      = r_div0;
    assign rem_err   = r_remErr;

endmodule

// File: tb/tb_unsigned_div_reconstructor.sv
// Directed and randomized checks of the reconstructor against q*d+r computed in plain arithmetic.
module tb_unsigned_div_reconstructor;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           out_ready = 1'b0;
    logic [W-1:0]   quotient = '0;
    logic [W-1:0]   divisor = '0;
    logic [W-1:0]   remainder = '0;
    logic           in_ready;
    logic           out_valid;
    logic [2*W-1:0] dividend;
    logic           div0;
    logic           rem_err;

    int checks = 0;
    int failures = 0;

    unsigned_div_reconstructor #(
        .WIDTH(W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .quotient  (quotient),
        .divisor   (divisor),
        .remainder (remainder),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dividend  (dividend),
        .div0      (div0),
        .rem_err   (rem_err)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Issue one triple, wait for the result, optionally stall the consumer, then complete the handshake.
    task automatic applyStimulus(input logic [W-1:0] q, input logic [W-1:0] d, input logic [W-1:0] r,
                                 input bit holdReady, input int stallCycles);
        logic [31:0] expDiv;
        logic        expDiv0;
        logic        expErr;
        int          edges;
        bit          leak;

        expDiv  = 32'(q) * 32'(d) + 32'(r);
        expDiv0 = (d == '0);
        expErr  = (d != '0) && (r >= d);

        @(negedge clk);
        quotient  = q;
        divisor   = d;
        remainder = r;
        in_valid  = 1'b1;
        out_ready = holdReady;
        checkOutput("in_ready_idle", 32'(in_ready), 32'd1);

        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        quotient  = W'($urandom);
        divisor   = W'($urandom);
        remainder = W'($urandom);
        edges = 1;
        leak  = 1'b0;
        while (!out_valid && edges < 4 * W) begin
            if (in_ready) leak = 1'b1;
            @(posedge clk);
            #1;
            edges++;
        end
        checkOutput("out_valid_timeout", 32'(out_valid), 32'd1);
        checkOutput("latency", 32'(edges), 32'(W + 1));
        checkOutput("in_ready_busy", 32'(leak), 32'd0);
        checkOutput("dividend", 32'(dividend), expDiv);
        checkOutput("div0", 32'(div0), 32'(expDiv0));
        checkOutput("rem_err", 32'(rem_err), 32'(expErr));

        for (int i = 0; i < stallCycles; i++) begin
            in_valid  = 1'b1;
            quotient  = W'($urandom);
            divisor   = W'($urandom);
            remainder = W'($urandom);
            @(posedge clk);
            #1;
            checkOutput("stall_out_valid", 32'(out_valid), 32'd1);
            checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
            checkOutput("stall_dividend", 32'(dividend), expDiv);
            checkOutput("stall_flags", 32'({div0, rem_err}), 32'({expDiv0, expErr}));
        end

        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("release_out_valid", 32'(out_valid), 32'd0);
        checkOutput("release_in_ready", 32'(in_ready), 32'd1);
        checkOutput("held_dividend", 32'(dividend), expDiv);
        out_ready = 1'b0;
    endtask

    initial begin
        bit sawValid;
        logic [W-1:0] rq;
        logic [W-1:0] rd;
        logic [W-1:0] rr;
        bit hold;

        $display("[TB] start");
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_dividend", 32'(dividend), 32'd0);
        checkOutput("reset_flags", 32'({div0, rem_err}), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        applyStimulus(8'd28, 8'd7, 8'd4, 1'b1, 0);
        applyStimulus(8'd255, 8'd255, 8'd254, 1'b0, 0);
        applyStimulus(8'd0, 8'd0, 8'd0, 1'b0, 0);
        applyStimulus(8'd255, 8'd0, 8'd255, 1'b1, 0);
        applyStimulus(8'd1, 8'd5, 8'd5, 1'b0, 0);
        applyStimulus(8'd3, 8'd5, 8'd4, 1'b0, 0);
        applyStimulus(8'd13, 8'd11, 8'd6, 1'b0, 5);

        // Abort a computation partway through RUN and make sure it never surfaces.
        @(negedge clk);
        quotient  = 8'd200;
        divisor   = 8'd3;
        remainder = 8'd1;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midrun_reset_in_ready", 32'(in_ready), 32'd1);
        checkOutput("midrun_reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("midrun_reset_dividend", 32'(dividend), 32'd0);
        checkOutput("midrun_reset_flags", 32'({div0, rem_err}), 32'd0);
        rst = 1'b0;
        sawValid = 1'b0;
        repeat (W + 3) begin
            @(posedge clk);
            #1;
            if (out_valid) sawValid = 1'b1;
        end
        checkOutput("midrun_reset_no_result", 32'(sawValid), 32'd0);

        applyStimulus(8'd10, 8'd10, 8'd9, 1'b1, 0);

        for (int n = 0; n < 24; n++) begin
            rq   = W'($urandom);
            rd   = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
            rr   = W'($urandom);
            hold = 1'($urandom_range(0, 1));
            applyStimulus(rq, rd, rr, hold, hold ? 0 : int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
